// File: rtl/pc_sequencer_if.sv
// Fetch/execute control bundle between the IF stage and the next-PC
// generator: EX resolution inputs, next PC and return-stack status.
interface pc_sequencer_if #(
    parameter int PC_W = 16
);
    logic            hazard;
    logic [PC_W-1:0] if_pc;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [15:0]     ex_instr;
    logic            branch;
    logic [PC_W-1:0] nxt_pc;
    logic            redirect;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_ovf;
    logic            ras_unf;

    modport master (
        output hazard, if_pc, ex_valid, ex_pc, ex_instr, branch,
        input  nxt_pc, redirect, ras_empty, ras_full, ras_ovf, ras_unf
    );

    modport slave (
        input  hazard, if_pc, ex_valid, ex_pc, ex_instr, branch,
        output nxt_pc, redirect, ras_empty, ras_full, ras_ovf, ras_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC generator for the IF stage: resolves delayed B/CALL/RET in EX
// and keeps a circular hardware return-address stack.
module pc_sequencer #(
    parameter int       PC_W      = 16,
    parameter int       RAS_DEPTH = 8,
    parameter int       DELAY     = 2,
    parameter bit [3:0] OP_B      = 4'hC,
    parameter bit [3:0] OP_CALL   = 4'hD,
    parameter bit [3:0] OP_RET    = 4'hE
) (
    input logic          clk,
    input logic          rst,
    pc_sequencer_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    typedef logic [PC_W-1:0] pc_t;

    pc_t           ras_q [RAS_DEPTH];
    pc_t           ras_d [RAS_DEPTH];
    logic [PW-1:0] tos_q, tos_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;

    logic [3:0]    op;
    logic          is_b, is_call, is_ret, has_ent;
    logic [PW-1:0] tos_inc;
    pc_t           seq_pc, br_tgt, call_tgt, ret_addr;

    always_comb begin
        op       = bus.ex_instr[15:12];
        is_b     = bus.ex_valid && (op == OP_B);
        is_call  = bus.ex_valid && (op == OP_CALL);
        is_ret   = bus.ex_valid && (op == OP_RET);
        has_ent  = (cnt_q != '0);
        tos_inc  = tos_q + PW'(1);
        seq_pc   = bus.hazard ? bus.if_pc : bus.if_pc + pc_t'(1);
        br_tgt   = bus.ex_pc + pc_t'(DELAY)
                 + {{(PC_W-8){bus.ex_instr[7]}}, bus.ex_instr[7:0]};
        // Page bits come from ex_pc; only the low 12 bits are encoded.
        call_tgt        = bus.ex_pc;
        call_tgt[11:0]  = bus.ex_instr[11:0];
        ret_addr = bus.ex_pc + pc_t'(DELAY);
    end

    always_comb begin
        bus.nxt_pc   = seq_pc;
        bus.redirect = 1'b0;
        unique case (1'b1)
            is_b && bus.branch: begin
                bus.nxt_pc   = br_tgt;
                bus.redirect = 1'b1;
            end
            is_call: begin
                bus.nxt_pc   = call_tgt;
                bus.redirect = 1'b1;
            end
            is_ret && has_ent: begin
                bus.nxt_pc   = ras_q[tos_q];
                bus.redirect = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ras_d = ras_q;
        tos_d = tos_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (is_call) begin
            tos_d          = tos_inc;
            ras_d[tos_inc] = ret_addr;
            // A full stack wraps onto its oldest entry.
            if (cnt_q < DEPTH_C) cnt_d = cnt_q + CW'(1);
            else                 ovf_d = 1'b1;
        end else if (is_ret) begin
            if (has_ent) begin
                tos_d = tos_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
            tos_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ras_q <= ras_d;
            tos_q <= tos_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign bus.ras_empty = (cnt_q == '0);
    assign bus.ras_full  = (cnt_q == DEPTH_C);
    assign bus.ras_ovf   = ovf_q;
    assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic
// against a queue-based return-stack reference model.
module tb_pc_sequencer;
    localparam int       PC_W    = 16;
    localparam int       DEPTH   = 8;
    localparam int       DELAY   = 2;
    localparam bit [3:0] OP_B    = 4'hC;
    localparam bit [3:0] OP_CALL = 4'hD;
    localparam bit [3:0] OP_RET  = 4'hE;
    localparam bit [3:0] OP_ALU  = 4'h1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(PC_W)) bus ();

    pc_sequencer #(
        .PC_W(PC_W), .RAS_DEPTH(DEPTH), .DELAY(DELAY),
        .OP_B(OP_B), .OP_CALL(OP_CALL), .OP_RET(OP_RET)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] ras_m[$];
    bit          m_ovf, m_unf;

    function automatic logic [15:0] m_seq();
        return bus.hazard ? bus.if_pc : bus.if_pc + 16'd1;
    endfunction

    function automatic logic [15:0] m_nxt();
        int off;
        if (!bus.ex_valid) return m_seq();
        case (bus.ex_instr[15:12])
            OP_B: begin
                if (!bus.branch) return m_seq();
                off = int'(bus.ex_instr[7:0]);
                if (off > 127) off = off - 256;
                return 16'(int'(bus.ex_pc) + DELAY + off);
            end
            OP_CALL: return (bus.ex_pc & 16'hF000) | (bus.ex_instr & 16'h0FFF);
            OP_RET:  return (ras_m.size() > 0) ? ras_m[$] : m_seq();
            default: return m_seq();
        endcase
    endfunction

    function automatic bit m_redir();
        if (!bus.ex_valid) return 1'b0;
        case (bus.ex_instr[15:12])
            OP_B:    return bus.branch;
            OP_CALL: return 1'b1;
            OP_RET:  return ras_m.size() > 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input bit v, input logic [3:0] op,
                         input logic [15:0] pc, input logic [11:0] lo,
                         input bit br, input bit hz,
                         input logic [15:0] ifpc);
        bus.ex_valid = v;
        bus.ex_instr = {op, lo};
        bus.ex_pc    = pc;
        bus.branch   = br;
        bus.hazard   = hz;
        bus.if_pc    = ifpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (bus.ex_valid) begin
            if (bus.ex_instr[15:12] == OP_CALL) begin
                ras_m.push_back(bus.ex_pc + 16'(DELAY));
                if (ras_m.size() > DEPTH) begin
                    void'(ras_m.pop_front());
                    m_ovf = 1'b1;
                end
            end else if (bus.ex_instr[15:12] == OP_RET) begin
                if (ras_m.size() > 0) void'(ras_m.pop_back());
                else m_unf = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, OP_ALU, 16'h0, 12'h0, 0, 0, 16'h0040);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.ras_empty !== 1'b1) begin
            failures++; $display("FAIL rst_empty_held got=%b exp=1", bus.ras_empty);
        end
        rst = 1'b0;
        ras_m.delete(); m_ovf = 0; m_unf = 0;
        #1;
        checks++;
        if (bus.nxt_pc !== 16'h0041) begin
            failures++; $display("FAIL reset_nxt got=%h exp=0041", bus.nxt_pc);
        end
        checks++;
        if (bus.redirect !== 1'b0 || bus.ras_empty !== 1'b1 || bus.ras_full !== 1'b0
            || bus.ras_ovf !== 1'b0 || bus.ras_unf !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b%b%b%b%b exp=01000", bus.redirect,
                     bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf);
        end
        drive(0, OP_ALU, 16'h0, 12'h0, 0, 1, 16'h0040);
        checks++;
        if (bus.nxt_pc !== 16'h0040) begin
            failures++; $display("FAIL reset_hazard got=%h exp=0040", bus.nxt_pc);
        end
    endtask

    task automatic test_branch();
        drive(1, OP_B, 16'h0100, 12'h0FE, 1, 1, 16'h0200);
        checks++;
        if (bus.nxt_pc !== 16'h0100 || bus.redirect !== 1'b1) begin
            failures++;
            $display("FAIL br_back got=%h/%b exp=0100/1", bus.nxt_pc, bus.redirect);
        end
        drive(1, OP_B, 16'h0100, 12'h0FE, 0, 0, 16'h0200);
        checks++;
        if (bus.nxt_pc !== 16'h0201 || bus.redirect !== 1'b0) begin
            failures++;
            $display("FAIL br_not_taken got=%h/%b exp=0201/0", bus.nxt_pc, bus.redirect);
        end
        drive(1, OP_B, 16'h0100, 12'h07F, 1, 0, 16'h0200);
        checks++;
        if (bus.nxt_pc !== 16'h0181) begin
            failures++; $display("FAIL br_fwd got=%h exp=0181", bus.nxt_pc);
        end
        drive(0, OP_B, 16'h0100, 12'h07F, 1, 0, 16'h0200);
        checks++;
        if (bus.nxt_pc !== 16'h0201 || bus.redirect !== 1'b0) begin
            failures++;
            $display("FAIL br_invalid got=%h/%b exp=0201/0", bus.nxt_pc, bus.redirect);
        end
        tick();
    endtask

    task automatic test_call_ret();
        drive(1, OP_CALL, 16'h3010, 12'h234, 0, 1, 16'h3011);
        checks++;
        if (bus.nxt_pc !== 16'h3234 || bus.redirect !== 1'b1) begin
            failures++;
            $display("FAIL call_tgt got=%h/%b exp=3234/1", bus.nxt_pc, bus.redirect);
        end
        tick();
        drive(1, OP_RET, 16'h3234, 12'h0, 0, 0, 16'h3235);
        checks++;
        if (bus.nxt_pc !== 16'h3012 || bus.redirect !== 1'b1) begin
            failures++;
            $display("FAIL call_ret got=%h/%b exp=3012/1", bus.nxt_pc, bus.redirect);
        end
        tick();
        drive(0, OP_ALU, 16'h0, 12'h0, 0, 0, 16'h3013);
        checks++;
        if (bus.ras_empty !== 1'b1) begin
            failures++; $display("FAIL call_ret_empty got=%b exp=1", bus.ras_empty);
        end
    endtask

    task automatic test_nested();
        logic [15:0] exp_ret [3];
        exp_ret[0] = 16'h0032; exp_ret[1] = 16'h0022; exp_ret[2] = 16'h0012;
        for (int i = 1; i <= 3; i++) begin
            drive(1, OP_CALL, 16'(i * 16'h10), 12'h500, 0, 0, 16'h0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, OP_RET, 16'h0500, 12'h0, 0, 0, 16'h0501);
            checks++;
            if (bus.nxt_pc !== exp_ret[i] || bus.redirect !== 1'b1) begin
                failures++;
                $display("FAIL nested_ret%0d got=%h exp=%h", i, bus.nxt_pc, exp_ret[i]);
            end
            tick();
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= DEPTH; i++) begin
            drive(1, OP_CALL, 16'(i * 16'h100), 12'h0AB, 0, 0, 16'h0);
            tick();
        end
        drive(0, OP_ALU, 16'h0, 12'h0, 0, 0, 16'h0700);
        checks++;
        if (bus.ras_full !== 1'b1 || bus.ras_ovf !== 1'b1 || bus.ras_empty !== 1'b0) begin
            failures++;
            $display("FAIL ovf_flags got=full%b ovf%b empty%b exp=1,1,0",
                     bus.ras_full, bus.ras_ovf, bus.ras_empty);
        end
        for (int i = DEPTH; i >= 1; i--) begin
            drive(1, OP_RET, 16'h0F00, 12'h0, 0, 0, 16'h0F01);
            checks++;
            if (bus.nxt_pc !== 16'(i * 16'h100 + DELAY)) begin
                failures++;
                $display("FAIL ovf_ret%0d got=%h exp=%h", i, bus.nxt_pc,
                         16'(i * 16'h100 + DELAY));
            end
            tick();
        end
        drive(1, OP_RET, 16'h0F00, 12'h0, 0, 0, 16'h0F01);
        checks++;
        if (bus.nxt_pc !== 16'h0F02 || bus.redirect !== 1'b0) begin
            failures++;
            $display("FAIL unf_default got=%h/%b exp=0F02/0", bus.nxt_pc, bus.redirect);
        end
        tick();
        checks++;
        if (bus.ras_unf !== 1'b1 || bus.ras_empty !== 1'b1) begin
            failures++;
            $display("FAIL unf_flag got=unf%b empty%b exp=1,1", bus.ras_unf, bus.ras_empty);
        end
    endtask

    task automatic test_async_rst();
        for (int i = 1; i <= 3; i++) begin
            drive(1, OP_CALL, 16'(i * 16'h40), 12'h111, 0, 0, 16'h0);
            tick();
        end
        drive(0, OP_ALU, 16'h0, 12'h0, 0, 0, 16'h0080);
        #2 rst = 1'b1;
        ras_m.delete(); m_ovf = 0; m_unf = 0;
        #1;
        checks++;
        if (bus.ras_empty !== 1'b1 || bus.ras_ovf !== 1'b0 || bus.ras_unf !== 1'b0) begin
            failures++;
            $display("FAIL arst_clear got=empty%b ovf%b unf%b exp=1,0,0",
                     bus.ras_empty, bus.ras_ovf, bus.ras_unf);
        end
        rst = 1'b0;
        @(negedge clk);
        drive(1, OP_RET, 16'h0200, 12'h0, 0, 0, 16'h0300);
        checks++;
        if (bus.nxt_pc !== 16'h0301 || bus.redirect !== 1'b0) begin
            failures++;
            $display("FAIL arst_ret got=%h/%b exp=0301/0", bus.nxt_pc, bus.redirect);
        end
        tick();
        checks++;
        if (bus.ras_unf !== 1'b1) begin
            failures++; $display("FAIL arst_unf got=%b exp=1", bus.ras_unf);
        end
        drive(0, OP_CALL, 16'h0400, 12'h123, 0, 0, 16'h0500);
        checks++;
        if (bus.nxt_pc !== 16'h0501 || bus.redirect !== 1'b0) begin
            failures++;
            $display("FAIL nv_call_nxt got=%h/%b exp=0501/0", bus.nxt_pc, bus.redirect);
        end
        tick();
        checks++;
        if (bus.ras_empty !== 1'b1) begin
            failures++; $display("FAIL nv_call_push got=%b exp=1", bus.ras_empty);
        end
    endtask

    task automatic test_random();
        logic [3:0] ops [4];
        ops[0] = OP_B; ops[1] = OP_CALL; ops[2] = OP_RET; ops[3] = OP_ALU;
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, ops[$urandom_range(0, 3)],
                  16'($urandom), 12'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom));
            checks++;
            if (bus.nxt_pc !== m_nxt() || bus.redirect !== m_redir()) begin
                failures++;
                $display("FAIL rnd_nxt n=%0d got=%h/%b exp=%h/%b", n,
                         bus.nxt_pc, bus.redirect, m_nxt(), m_redir());
            end
            checks++;
            if (bus.ras_empty !== (ras_m.size() == 0)
                || bus.ras_full !== (ras_m.size() == DEPTH)
                || bus.ras_ovf !== m_ovf || bus.ras_unf !== m_unf) begin
                failures++;
                $display("FAIL rnd_flags n=%0d got=%b%b%b%b exp=%b%b%b%b", n,
                         bus.ras_empty, bus.ras_full, bus.ras_ovf, bus.ras_unf,
                         ras_m.size() == 0, ras_m.size() == DEPTH, m_ovf, m_unf);
            end
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_branch();
        test_call_ret();
        test_nested();
        test_overflow();
        test_async_rst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
